mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers. Sits directly downstream of the register file in the MIPS datapath: it consumes ReadData1/ReadData2 as operands for MULT, MULTU, DIV and DIVU. Results go into HI/LO for later MFHI/MFLO. A Busy flag lets the hazard/stall logic hold the pipeline while an operation is in flight.

---
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; one iteration per cycle, 32 cycles.
module mult_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] MoveData,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        is_div_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic        neg_rem_q;
  logic        div_zero_q;
  logic [31:0] orig_a_q;
  logic [31:0] hi_q, lo_q;

  logic        signed_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [63:0] acc_step;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] res_hi, res_lo;
  logic        accept;

  assign signed_op = ~Op[0];
  assign sign_a    = signed_op & OperandA[31];
  assign sign_b    = signed_op & OperandB[31];
  assign mag_a     = sign_a ? -OperandA : OperandA;
  assign mag_b     = sign_b ? -OperandB : OperandB;
  assign accept    = Start && (state_q != S_RUN);

  // opnd_q holds the multiplicand (|A|) for multiply and the divisor (|B|) for divide;
  // acc_q low half starts as the multiplier or the dividend respectively.
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    trial    = acc_q[63:31] - {1'b0, opnd_q};
    acc_step = {add_sum, acc_q[31:1]};
    if (is_div_q) begin
      if (trial[32]) acc_step = {acc_q[62:0], 1'b0};
      else           acc_step = {trial[31:0], acc_q[30:0], 1'b1};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    quot_fix = neg_q ? -acc_step[31:0] : acc_step[31:0];
    rem_fix  = neg_rem_q ? -acc_step[63:32] : acc_step[63:32];
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = orig_a_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = Start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      orig_a_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_RUN) begin
        if (HiWrite) hi_q <= MoveData;
        if (LoWrite) lo_q <= MoveData;
      end
      if (accept) begin
        is_div_q   <= Op[1];
        opnd_q     <= Op[1] ? mag_b : mag_a;
        acc_q      <= {32'd0, (Op[1] ? mag_a : mag_b)};
        cnt_q      <= '0;
        neg_q      <= sign_a ^ sign_b;
        neg_rem_q  <= sign_a;
        div_zero_q <= (OperandB == 32'd0);
        orig_a_q   <= OperandA;
      end else if (state_q == S_RUN) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 5'd1;
        // Last iteration: the fixed-up result lands on the same edge that enters DONE.
        if (cnt_q == 5'd31) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = (state_q == S_RUN);
  assign Done = (state_q == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency, interlock and reset abort.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic [31:0] OperandA = '0;
  logic [31:0] OperandB = '0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] MoveData = '0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

  mult_div_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .MoveData(MoveData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the Start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Counts Busy cycles until Done, optionally scrambling inputs while running.
  task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input bit noise);
    int busy_cnt = 0;
    bit got = 0;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busy_cnt++;
      if (Done) begin got = 1; break; end
      if (noise) begin
        Start    = i[0];
        HiWrite  = ~i[0];
        LoWrite  = i[0];
        Op       = i[1:0];
        OperandA = $urandom;
        OperandB = $urandom;
        MoveData = $urandom | 32'h1;
      end
      @(negedge Clk);
    end
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
    $display("op %s: hi=%08h lo=%08h busy_cycles=%0d", tag, Hi, Lo, busy_cnt);
  endtask

  task automatic after_done(input string tag);
    @(negedge Clk);
    check({tag, "_done_pulse"}, 64'(Done), 64'd0);
    check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("reset_hi", 64'(Hi), 64'd0);
    check("reset_lo", 64'(Lo), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);
    after_done("multu_max");

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    after_done("mult_neg");

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    after_done("div_neg");

    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done("divu_zero", 32'd100, 32'hFFFF_FFFF, 0);
    after_done("divu_zero");

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'd0, 32'h8000_0000, 0);
    after_done("div_ovf");

    issue(OP_DIVU, 32'd1000, 32'd7);
    wait_done("divu_noise", 32'd6, 32'd142, 1);
    after_done("divu_noise");

    LoWrite = 1'b1; MoveData = 32'h1234;
    @(negedge Clk);
    LoWrite = 1'b0;
    check("mtlo_lo", 64'(Lo), 64'h1234);
    check("mtlo_hi_kept", 64'(Hi), 64'd6);
    $display("op mtlo: hi=%08h lo=%08h", Hi, Lo);

    // Back-to-back: second Start presented during the DONE cycle.
    issue(OP_DIVU, 32'd50, 32'd8);
    wait_done("b2b_first", 32'd2, 32'd6, 0);
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_done("b2b_second", 32'd0, 32'd30, 0);
    after_done("b2b_second");

    // Reset aborts a DIV mid-run.
    issue(OP_DIV, 32'd12345, 32'd3);
    repeat (15) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_hi", 64'(Hi), 64'd0);
    check("abort_lo", 64'(Lo), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    begin
      int done_seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge Clk);
        if (Done) done_seen++;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);
    end
    $display("op reset_abort: hi=%08h lo=%08h busy=%0b", Hi, Lo, Busy);

    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done("multu_after_reset", 32'd0, 32'd6, 0);
    after_done("multu_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
